// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the fetch/next-PC sequencer.
// Holds the PC width, the reset PC, default step/alignment, the state enum
// and a helper that clears the low alignment bits of an address.
package pc_sequencer_pkg;

  localparam int REG_END_WORD = 31;
  localparam int PC_W         = REG_END_WORD + 1;

  localparam logic [PC_W-1:0] INITIAL_PC = PC_W'(32'h0000_0040);

  localparam int PC_STEP_DEF   = 4;
  localparam int ALIGN_LSB_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } seq_state_t;

  // Clear the lowest lsb bits of an address.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr,
                                               input int lsb);
    logic [PC_W-1:0] mask;
    mask = '1;
    mask = mask << lsb;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: purely combinational next-PC selection.
// Priority is trap, then redirect, then sequential (pc_cur + PC_STEP, which
// wraps at the PC width). The result always has its ALIGN_LSB low bits cleared.
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter int PC_STEP   = PC_STEP_DEF,
  parameter int ALIGN_LSB = ALIGN_LSB_DEF
) (
  input  logic [PC_W-1:0] pc_cur,
  input  logic            trap_sel,
  input  logic [PC_W-1:0] trap_addr,
  input  logic            redirect_sel,
  input  logic [PC_W-1:0] redirect_addr,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_raw;

  assign pc_seq = pc_cur + PC_W'(PC_STEP);

  // Fixed-priority choice of the unaligned next PC.
  always_comb begin
    pc_raw = pc_seq;
    if (trap_sel) begin
      pc_raw = trap_addr;
    end else if (redirect_sel) begin
      pc_raw = redirect_addr;
    end
  end

  assign pc_next = align_pc(pc_raw, ALIGN_LSB);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / execute / retire controller that owns the PC write
// port. Chooses the next PC at every retire (trap > redirect > sequential)
// and parks in S_HALT on request.
// Optional build macro PC_SEQ_PERF_EN adds retired_cnt and fetch_stall_cnt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | just out of reset; ifu_ack ignored, pick fetch or halt
// S_FETCH | ifu_req held with ifu_addr = pc_rdata until ifu_ack
// S_EXEC  | insn_valid high; insn_ready retires and writes the PC
// S_HALT  | parked, no requests; leaves on pending trap or halt low
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_STEP   = PC_STEP_DEF,
  parameter int ALIGN_LSB = ALIGN_LSB_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_rdata,
  output logic            pc_wen,
  output logic [PC_W-1:0] pc_wdata,
  output logic            ifu_req,
  output logic [PC_W-1:0] ifu_addr,
  input  logic            ifu_ack,
  output logic            insn_valid,
  input  logic            insn_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_vector,
  input  logic            halt,
  output logic            halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     fetch_stall_cnt
`endif
);

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic            trap_pending;
  logic [PC_W-1:0] trap_vec_q;
  logic            retire;
  logic            halt_trap_exit;
  logic            trap_consume;
  logic            trap_sel;
  logic [PC_W-1:0] trap_addr;
  logic [PC_W-1:0] pc_next;

  assign retire         = (state == S_EXEC) && insn_ready;
  assign halt_trap_exit = (state == S_HALT) && trap_pending;
  assign trap_consume   = retire || halt_trap_exit;

  // A trap arriving in the consuming cycle is newer than the captured one.
  assign trap_sel  = trap_valid || trap_pending;
  assign trap_addr = trap_valid ? trap_vector : trap_vec_q;

  pc_next_sel #(
    .PC_STEP   (PC_STEP),
    .ALIGN_LSB (ALIGN_LSB)
  ) u_next_sel (
    .pc_cur        (pc_rdata),
    .trap_sel      (trap_sel),
    .trap_addr     (trap_addr),
    .redirect_sel  (redirect_valid),
    .redirect_addr (redirect_target),
    .pc_next       (pc_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = halt ? S_HALT : S_FETCH;
      S_FETCH: if (ifu_ack) state_nxt = S_EXEC;
      S_EXEC:  if (insn_ready) state_nxt = halt ? S_HALT : S_FETCH;
      S_HALT:  if (trap_pending || !halt) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; the PC is written only on retire or on a trap leaving S_HALT.
  always_comb begin
    ifu_req    = 1'b0;
    ifu_addr   = '0;
    insn_valid = 1'b0;
    pc_wen     = 1'b0;
    pc_wdata   = '0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        ifu_req  = 1'b1;
        ifu_addr = pc_rdata;
      end
      S_EXEC: begin
        insn_valid = 1'b1;
        if (insn_ready) begin
          pc_wen   = 1'b1;
          pc_wdata = pc_next;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (trap_pending) begin
          pc_wen   = 1'b1;
          pc_wdata = pc_next;
        end
      end
      default: ;
    endcase
  end

  // Remember a trap seen outside a consuming cycle; latest trap wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      trap_pending <= 1'b0;
      trap_vec_q   <= '0;
    end else if (trap_consume) begin
      trap_pending <= 1'b0;
    end else if (trap_valid) begin
      trap_pending <= 1'b1;
      trap_vec_q   <= trap_vector;
    end
  end

`ifdef PC_SEQ_PERF_EN
  // Retire and fetch-stall event counters, free-running modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt     <= '0;
      fetch_stall_cnt <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if ((state == S_FETCH) && !ifu_ack) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed sequences, a retire vector table and a randomized
// run against a behavioural model of the sequencer and its PC register.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int STEP = 4;
  localparam int ALN  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_PARK  = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [PC_W-1:0] pc_reg;
  logic            pc_wen;
  logic [PC_W-1:0] pc_wdata;
  logic            ifu_req;
  logic [PC_W-1:0] ifu_addr;
  logic            ifu_ack;
  logic            insn_valid;
  logic            insn_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            trap_valid;
  logic [PC_W-1:0] trap_vector;
  logic            halt;
  logic            halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]     retired_cnt;
  logic [31:0]     fetch_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .pc_rdata        (pc_reg),
    .pc_wen          (pc_wen),
    .pc_wdata        (pc_wdata),
    .ifu_req         (ifu_req),
    .ifu_addr        (ifu_addr),
    .ifu_ack         (ifu_ack),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt            (halt),
    .halted          (halted)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_cnt     (retired_cnt),
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] target;
    logic        trap;
    logic [31:0] vec;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // The PC register this block writes: updated at the clock edge.
  task automatic commit();
    logic            w;
    logic [PC_W-1:0] d;
    w = pc_wen;
    d = pc_wdata;
    @(posedge clock);
    #1;
    if (reset) pc_reg = INITIAL_PC;
    else if (w) pc_reg = d;
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] v);
    return v - (v % (32'd1 << ALN));
  endfunction

  function automatic logic [31:0] ref_seq(input logic [31:0] v);
    logic [32:0] s;
    s = {1'b0, v} + 33'(STEP);
    return s[31:0];
  endfunction

  task automatic quiet();
    ifu_ack = 0; insn_ready = 0; redirect_valid = 0; trap_valid = 0;
    redirect_target = '0; trap_vector = '0;
  endtask

  // model state for the randomized run
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_tp;
  logic [31:0] m_tv;
  logic [31:0] m_ret;
  logic [31:0] m_stall;

  initial begin
    logic        seen;
    logic        e_req, e_valid, e_halted, e_wen, retire_now, tp_old;
    logic [31:0] choice, e_wdata;

    tbl[0] = '{pc: 32'hFFFF_FFFC, redir: 0, target: 32'h0,         trap: 0, vec: 32'h0,         exp: 32'h0000_0000};
    tbl[1] = '{pc: 32'h0000_0200, redir: 1, target: 32'h0000_0ABF, trap: 0, vec: 32'h0,         exp: 32'h0000_0ABC};
    tbl[2] = '{pc: 32'h1234_5678, redir: 0, target: 32'h0,         trap: 0, vec: 32'h0,         exp: 32'h1234_567C};
    tbl[3] = '{pc: 32'h0000_0010, redir: 1, target: 32'h0000_5000, trap: 1, vec: 32'h0000_0803, exp: 32'h0000_0800};
    tbl[4] = '{pc: 32'h8000_0001, redir: 0, target: 32'h0,         trap: 0, vec: 32'h0,         exp: 32'h8000_0004};
    tbl[5] = '{pc: 32'h0000_0000, redir: 0, target: 32'h0,         trap: 1, vec: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFC};

    quiet();
    halt = 0;
    reset = 1;
    pc_reg = INITIAL_PC;

    // reset state
    @(negedge clock); commit();
    @(negedge clock);
    check("rst_req", 32'(ifu_req), 0);
    check("rst_valid", 32'(insn_valid), 0);
    check("rst_wen", 32'(pc_wen), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_wdata", pc_wdata, 0);
    commit();

    // first fetch, memory acks after two waiting cycles
    reset = 0;
    @(negedge clock); check("idle_req", 32'(ifu_req), 0); commit();
    @(negedge clock);
    check("f1_req", 32'(ifu_req), 1);
    check("f1_addr", ifu_addr, INITIAL_PC);
    commit();
    @(negedge clock); check("f2_addr", ifu_addr, INITIAL_PC); commit();
    ifu_ack = 1;
    @(negedge clock); check("ack_valid", 32'(insn_valid), 0); commit();
    ifu_ack = 0; insn_ready = 1;
    @(negedge clock);
    check("ex_valid", 32'(insn_valid), 1);
    check("ret_wen", 32'(pc_wen), 1);
    check("ret_seq", pc_wdata, INITIAL_PC + 32'd4);
    commit();

    // redirect with unaligned target
    insn_ready = 0; ifu_ack = 1;
    @(negedge clock); check("f_addr2", ifu_addr, INITIAL_PC + 32'd4); commit();
    ifu_ack = 0; insn_ready = 1; redirect_valid = 1; redirect_target = 32'h0000_1002;
    @(negedge clock);
    check("redir_wen", 32'(pc_wen), 1);
    check("redir_wdata", pc_wdata, 32'h0000_1000);
    commit();
    quiet();
    @(negedge clock); check("redir_faddr", ifu_addr, 32'h0000_1000); commit();

    // trap during fetch beats a later redirect, then is gone
    trap_valid = 1; trap_vector = 32'h0000_0100;
    @(negedge clock); check("trapf_wen", 32'(pc_wen), 0); commit();
    trap_valid = 0; ifu_ack = 1;
    @(negedge clock); commit();
    ifu_ack = 0; insn_ready = 1; redirect_valid = 1; redirect_target = 32'h0000_2000;
    @(negedge clock); check("trap_wdata", pc_wdata, 32'h0000_0100); commit();
    quiet(); ifu_ack = 1;
    @(negedge clock); check("trap_faddr", ifu_addr, 32'h0000_0100); commit();
    ifu_ack = 0; insn_ready = 1;
    @(negedge clock); check("trap_cleared", pc_wdata, 32'h0000_0104); commit();

    // halt after retire, trap wakes the sequencer
    quiet(); ifu_ack = 1;
    @(negedge clock); commit();
    ifu_ack = 0; insn_ready = 1; halt = 1;
    @(negedge clock); check("halt_ret", pc_wdata, 32'h0000_0108); commit();
    insn_ready = 0;
    @(negedge clock);
    check("halted", 32'(halted), 1);
    check("halt_req", 32'(ifu_req), 0);
    check("halt_wen", 32'(pc_wen), 0);
    commit();
    @(negedge clock); check("halted2", 32'(halted), 1); commit();
    trap_valid = 1; trap_vector = 32'h0000_0300;
    @(negedge clock); check("halt_trap_wen0", 32'(pc_wen), 0); commit();
    trap_valid = 0;
    @(negedge clock);
    check("halt_trap_wen", 32'(pc_wen), 1);
    check("halt_trap_wdata", pc_wdata, 32'h0000_0300);
    commit();
    halt = 0;
    @(negedge clock);
    check("wake_halted", 32'(halted), 0);
    check("wake_addr", ifu_addr, 32'h0000_0300);
    commit();

    // reset while a fetch is acked in the same cycle
    reset = 1; ifu_ack = 1;
    @(negedge clock); check("pre_rst_req", 32'(ifu_req), 1); commit();
    reset = 0; ifu_ack = 0;
    @(negedge clock);
    check("rst_ack_valid", 32'(insn_valid), 0);
    check("rst_ack_wen", 32'(pc_wen), 0);
    check("rst_ack_req", 32'(ifu_req), 0);
    commit();
    @(negedge clock); check("rst_ack_faddr", ifu_addr, INITIAL_PC); commit();

    // retire vector table
    foreach (tbl[i]) begin
      quiet(); ifu_ack = 1;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clock);
        seen = insn_valid;
        commit();
      end
      check("tbl_reach_exec", 32'(seen), 1);
      ifu_ack = 0;
      pc_reg = tbl[i].pc;
      redirect_valid = tbl[i].redir; redirect_target = tbl[i].target;
      trap_valid = tbl[i].trap; trap_vector = tbl[i].vec;
      insn_ready = 1;
      @(negedge clock);
      check($sformatf("tbl%0d_wen", i), 32'(pc_wen), 1);
      check($sformatf("tbl%0d_wdata", i), pc_wdata, tbl[i].exp);
      commit();
    end

    // randomized run against the model
    quiet(); halt = 0; reset = 1;
    @(negedge clock); commit();
    m_mode = M_IDLE; m_pc = INITIAL_PC; m_tp = 0; m_tv = 0; m_ret = 0; m_stall = 0;
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      ifu_ack         = ($urandom_range(0, 2) == 0);
      insn_ready      = $urandom_range(0, 1) == 1;
      redirect_valid  = ($urandom_range(0, 2) == 0);
      redirect_target = $urandom;
      trap_valid      = ($urandom_range(0, 14) == 0);
      trap_vector     = $urandom;
      @(negedge clock);

      e_req      = (m_mode == M_FETCH);
      e_valid    = (m_mode == M_EXEC);
      e_halted   = (m_mode == M_PARK);
      retire_now = e_valid && insn_ready;
      e_wen      = retire_now || (e_halted && m_tp);
      if (trap_valid) choice = trap_vector;
      else if (m_tp) choice = m_tv;
      else if (redirect_valid) choice = redirect_target;
      else choice = ref_seq(m_pc);
      e_wdata = e_wen ? ref_align(choice) : 32'd0;

      check("rnd_req", 32'(ifu_req), 32'(e_req));
      check("rnd_valid", 32'(insn_valid), 32'(e_valid));
      check("rnd_halted", 32'(halted), 32'(e_halted));
      check("rnd_wen", 32'(pc_wen), 32'(e_wen));
      check("rnd_wdata", pc_wdata, e_wdata);
      if (e_req) check("rnd_addr", ifu_addr, m_pc);

      tp_old = m_tp;
      if (reset) begin
        m_mode = M_IDLE; m_tp = 0; m_pc = INITIAL_PC; m_ret = 0; m_stall = 0;
      end else begin
        if (e_wen) m_pc = e_wdata;
        if (retire_now) m_ret++;
        if (e_req && !ifu_ack) m_stall++;
        if (e_wen) m_tp = 0;
        else if (trap_valid) begin m_tp = 1; m_tv = trap_vector; end
        case (m_mode)
          M_IDLE:  m_mode = halt ? M_PARK : M_FETCH;
          M_FETCH: if (ifu_ack) m_mode = M_EXEC;
          M_EXEC:  if (insn_ready) m_mode = halt ? M_PARK : M_FETCH;
          default: if (tp_old || !halt) m_mode = M_FETCH;
        endcase
      end
      commit();
    end
`ifdef PC_SEQ_PERF_EN
    check("perf_retired", retired_cnt, m_ret);
    check("perf_stall", fetch_stall_cnt, m_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
